// File: rtl/frame_sync_ctrl_if.sv
// Bit-stream and frame-qualification signals between the link front end,
// the frame synchronizer and the downstream decoder.
interface frame_sync_ctrl_if #(
  parameter int FRAME_LEN = 32
);
  logic                         bit_en;
  logic                         bit_in;
  logic                         locked;
  logic                         frame_start;
  logic                         payload_en;
  logic                         payload_bit;
  logic                         head_miss;
  logic [$clog2(FRAME_LEN)-1:0] bit_pos;
  logic [1:0]                   state;

  modport master (
    output bit_en, bit_in,
    input  locked, frame_start, payload_en, payload_bit, head_miss, bit_pos, state
  );

  modport slave (
    input  bit_en, bit_in,
    output locked, frame_start, payload_en, payload_bit, head_miss, bit_pos, state
  );
endinterface

// File: rtl/frame_sync_ctrl.sv
// Receive frame synchronizer: hunts for the frame head, confirms it over
// several frames, then flywheels on the frame period and qualifies payload.
//
// state | meaning
// HUNT  | scanning every bit window for the head pattern
// CHECK | head seen, confirming it at the following frame boundaries
// SYNC  | locked; payload qualified, repeated head misses drop lock
module frame_sync_ctrl #(
  parameter int                  HEAD_LEN  = 6,
  parameter logic [HEAD_LEN-1:0] HEAD      = 6'b100101,
  parameter int                  FRAME_LEN = 32,
  parameter int                  LOCK_CNT  = 3,
  parameter int                  LOSS_CNT  = 3
) (
  input logic              clk_sys,
  input logic              reset,
  frame_sync_ctrl_if.slave fs
);
  localparam int PW = $clog2(FRAME_LEN);
  localparam int HW = $clog2(LOCK_CNT + 1);
  localparam int MW = $clog2(LOSS_CNT + 1);
  localparam logic [PW-1:0] POS_LAST = PW'(FRAME_LEN - 1);
  localparam logic [PW-1:0] PAY_LEN  = PW'(FRAME_LEN - HEAD_LEN);

  typedef enum logic [1:0] {
    ST_HUNT  = 2'd0,
    ST_CHECK = 2'd1,
    ST_SYNC  = 2'd2
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [HEAD_LEN-1:0] r_shreg, w_shreg_nxt;
  logic [PW-1:0]       r_pos, w_pos_nxt;
  logic [HW-1:0]       r_hits, w_hits_nxt;
  logic [MW-1:0]       r_misses, w_misses_nxt;
  logic                r_frame_start, w_frame_start_nxt;
  logic                r_payload_en, w_payload_en_nxt;
  logic                r_payload_bit, w_payload_bit_nxt;
  logic                r_head_miss, w_head_miss_nxt;

  logic [HEAD_LEN-1:0] w_cand;
  logic                w_match;
  logic                w_slot;
  logic [HW-1:0]       w_hits_inc;
  logic [MW-1:0]       w_misses_inc;

  assign w_cand       = {r_shreg[HEAD_LEN-2:0], fs.bit_in};
  assign w_match      = (w_cand == HEAD);
  assign w_slot       = (r_pos == POS_LAST);
  assign w_hits_inc   = r_hits + HW'(1);
  assign w_misses_inc = r_misses + MW'(1);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state       <= ST_HUNT;
      r_shreg       <= '0;
      r_pos         <= '0;
      r_hits        <= '0;
      r_misses      <= '0;
      r_frame_start <= 1'b0;
      r_payload_en  <= 1'b0;
      r_payload_bit <= 1'b0;
      r_head_miss   <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_shreg       <= w_shreg_nxt;
      r_pos         <= w_pos_nxt;
      r_hits        <= w_hits_nxt;
      r_misses      <= w_misses_nxt;
      r_frame_start <= w_frame_start_nxt;
      r_payload_en  <= w_payload_en_nxt;
      r_payload_bit <= w_payload_bit_nxt;
      r_head_miss   <= w_head_miss_nxt;
    end
  end

  // Outside HUNT the head is only examined at the check slot; the slot bit
  // itself is never reused as a fresh head candidate.
  always_comb begin
    w_state_nxt  = r_state;
    w_shreg_nxt  = r_shreg;
    w_pos_nxt    = r_pos;
    w_hits_nxt   = r_hits;
    w_misses_nxt = r_misses;
    if (fs.bit_en) begin
      w_shreg_nxt = w_cand;
      case (r_state)
        ST_HUNT: begin
          w_pos_nxt = '0;
          if (w_match) begin
            w_state_nxt = ST_CHECK;
            w_hits_nxt  = HW'(1);
          end
        end
        ST_CHECK: begin
          if (w_slot) begin
            w_pos_nxt = '0;
            if (w_match) begin
              w_hits_nxt = w_hits_inc;
              if (w_hits_inc == HW'(LOCK_CNT)) begin
                w_state_nxt  = ST_SYNC;
                w_misses_nxt = '0;
              end
            end else begin
              w_state_nxt = ST_HUNT;
            end
          end else begin
            w_pos_nxt = r_pos + PW'(1);
          end
        end
        ST_SYNC: begin
          if (w_slot) begin
            w_pos_nxt = '0;
            if (w_match) begin
              w_misses_nxt = '0;
            end else begin
              w_misses_nxt = w_misses_inc;
              if (w_misses_inc == MW'(LOSS_CNT)) begin
                w_state_nxt = ST_HUNT;
              end
            end
          end else begin
            w_pos_nxt = r_pos + PW'(1);
          end
        end
        default: begin
          w_state_nxt = ST_HUNT;
          w_pos_nxt   = '0;
        end
      endcase
    end
  end

  always_comb begin
    w_payload_en_nxt  = fs.bit_en && (r_state == ST_SYNC) && (r_pos < PAY_LEN);
    w_frame_start_nxt = w_payload_en_nxt && (r_pos == '0);
    w_payload_bit_nxt = w_payload_en_nxt ? fs.bit_in : r_payload_bit;
    w_head_miss_nxt   = fs.bit_en && w_slot && !w_match &&
                        ((r_state == ST_CHECK) || (r_state == ST_SYNC));
  end

  assign fs.locked      = (r_state == ST_SYNC);
  assign fs.state       = r_state;
  assign fs.bit_pos     = r_pos;
  assign fs.frame_start = r_frame_start;
  assign fs.payload_en  = r_payload_en;
  assign fs.payload_bit = r_payload_bit;
  assign fs.head_miss   = r_head_miss;
endmodule

// File: tb/tb_frame_sync_ctrl.sv
// Self-checking bench for frame_sync_ctrl: stimulus pushes expected payload
// bits into a scoreboard, a negedge monitor pops them as the DUT flags payload.
module tb_frame_sync_ctrl;
  localparam logic [5:0] HEAD = 6'b100101;
  localparam logic [5:0] BAD  = 6'b100100;

  typedef struct packed {
    logic b;
    logic first;
  } sb_t;

  logic clk_sys = 1'b0;
  logic reset   = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_miss   = 0;
  int   gap      = 3;
  sb_t  sb_q[$];

  frame_sync_ctrl_if #(.FRAME_LEN(32)) fsif ();

  frame_sync_ctrl dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .fs      (fsif)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  always @(negedge clk_sys) begin
    sb_t e;
    if (fsif.head_miss === 1'b1) n_miss++;
    if (fsif.payload_en === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("pay_extra", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk("pay_bit", 32'(fsif.payload_bit), 32'(e.b));
        chk("pay_first", 32'(fsif.frame_start), 32'(e.first));
      end
    end else if (fsif.frame_start === 1'b1) begin
      chk("fs_orphan", 32'd1, 32'd0);
    end
  end

  function automatic logic [11:0] out_vec();
    return {fsif.locked, fsif.frame_start, fsif.payload_en, fsif.payload_bit,
            fsif.head_miss, fsif.bit_pos, fsif.state};
  endfunction

  // Called at #1 after an edge; leaves the bench at #1 after the bit's edge.
  task automatic send_bit(input logic b, input bit pay, input bit first);
    repeat (gap) begin
      @(posedge clk_sys);
      #1;
    end
    if (pay) sb_q.push_back('{b: b, first: first});
    fsif.bit_en = 1'b1;
    fsif.bit_in = b;
    @(posedge clk_sys);
    #1;
    fsif.bit_en = 1'b0;
  endtask

  task automatic head_end(input string tag, input int exp_state, input bit exp_miss);
    chk({tag, "_state"}, 32'(fsif.state), 32'(exp_state));
    chk({tag, "_locked"}, 32'(fsif.locked), (exp_state == 2) ? 32'd1 : 32'd0);
    chk({tag, "_miss"}, 32'(fsif.head_miss), 32'(exp_miss));
    if (exp_state != 0) chk({tag, "_pos"}, 32'(fsif.bit_pos), 32'd0);
  endtask

  task automatic send_frame(input string tag, input logic [5:0] hd, input int exp_state,
                            input bit exp_miss, input int n_pay);
    for (int i = 5; i >= 0; i--) send_bit(hd[i], 1'b0, 1'b0);
    head_end(tag, exp_state, exp_miss);
    for (int i = 0; i < n_pay; i++)
      send_bit(1'($urandom_range(0, 1)), exp_state == 2, i == 0);
  endtask

  task automatic send_zeros(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset(input string tag, input int cycles);
    reset = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      fsif.bit_en = 1'($urandom_range(0, 1));
      fsif.bit_in = 1'($urandom_range(0, 1));
      @(posedge clk_sys);
      #1;
    end
    chk({tag, "_rst_outs"}, 32'(out_vec()), 32'd0);
    reset       = 1'b0;
    fsif.bit_en = 1'b0;
    fsif.bit_in = 1'b0;
    sb_q.delete();
    n_miss = 0;
  endtask

  task automatic scenario_end(input string tag, input int exp_miss);
    @(posedge clk_sys);
    #1;
    @(negedge clk_sys);
    #1;
    chk({tag, "_sb_empty"}, 32'(sb_q.size()), 32'd0);
    chk({tag, "_miss_cnt"}, 32'(n_miss), 32'(exp_miss));
    @(posedge clk_sys);
    #1;
  endtask

  task automatic clean_lock(input string tag, input int extra_frames);
    send_zeros($urandom_range(0, 9));
    send_frame({tag, "_h1"}, HEAD, 1, 1'b0, 26);
    send_frame({tag, "_h2"}, HEAD, 1, 1'b0, 26);
    send_frame({tag, "_h3"}, HEAD, 2, 1'b0, 26);
    for (int i = 0; i < extra_frames; i++)
      send_frame({tag, "_hs"}, HEAD, 2, 1'b0, 26);
  endtask

  initial begin
    fsif.bit_en = 1'b0;
    fsif.bit_in = 1'b0;
    @(posedge clk_sys);
    #1;

    // Reset with random inputs, then idle
    do_reset("a", 5);
    for (int i = 0; i < 50; i++) begin
      @(posedge clk_sys);
      #1;
      chk("a_idle", 32'(out_vec()), 32'd0);
    end

    // Clean stream
    do_reset("b", 2);
    clean_lock("b", 2);
    scenario_end("b", 0);

    // Fake head in payload, mismatch at its check slot, then true lock
    do_reset("c", 2);
    send_zeros(4);
    send_frame("c_fake", HEAD, 1, 1'b0, 0);
    send_zeros(20);
    for (int i = 5; i >= 0; i--) send_bit(HEAD[i], 1'b0, 1'b0);
    chk("c_ignore_state", 32'(fsif.state), 32'd1);
    send_zeros(6);
    head_end("c_drop", 0, 1'b1);
    send_zeros(20);
    send_frame("c_h1", HEAD, 1, 1'b0, 26);
    send_frame("c_h2", HEAD, 1, 1'b0, 26);
    send_frame("c_h3", HEAD, 2, 1'b0, 26);
    scenario_end("c", 1);

    // Head misses while locked: recover, then lose lock
    do_reset("d", 2);
    clean_lock("d", 1);
    send_frame("d_bad1", BAD, 2, 1'b1, 26);
    send_frame("d_bad2", BAD, 2, 1'b1, 26);
    send_frame("d_good", HEAD, 2, 1'b0, 26);
    send_frame("d_bad3", BAD, 2, 1'b1, 26);
    send_frame("d_bad4", BAD, 2, 1'b1, 26);
    send_frame("d_bad5", BAD, 0, 1'b1, 26);
    scenario_end("d", 5);

    // Back-to-back bits
    gap = 0;
    do_reset("e", 2);
    clean_lock("e", 2);
    scenario_end("e", 0);
    gap = 3;

    // Reset mid-payload while locked, then relock
    do_reset("f", 2);
    send_frame("f_h1", HEAD, 1, 1'b0, 26);
    send_frame("f_h2", HEAD, 1, 1'b0, 26);
    send_frame("f_h3", HEAD, 2, 1'b0, 10);
    reset       = 1'b1;
    fsif.bit_en = 1'b1;
    fsif.bit_in = 1'b1;
    @(posedge clk_sys);
    #1;
    chk("f_rst_outs", 32'(out_vec()), 32'd0);
    reset       = 1'b0;
    fsif.bit_en = 1'b0;
    fsif.bit_in = 1'b0;
    @(negedge clk_sys);
    #1;
    chk("f_sb_after_rst", 32'(sb_q.size()), 32'd0);
    sb_q.delete();
    n_miss = 0;
    @(posedge clk_sys);
    #1;
    send_frame("f_r1", HEAD, 1, 1'b0, 26);
    send_frame("f_r2", HEAD, 1, 1'b0, 26);
    send_frame("f_r3", HEAD, 2, 1'b0, 26);
    send_frame("f_r4", HEAD, 2, 1'b0, 26);
    scenario_end("f", 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/frame_sync_ctrl.md
# frame_sync_ctrl

Receive-side frame synchronizer and sequencer for the ComSys link. It watches the recovered serial bit stream, hunts for the 6-bit frame head, confirms it over several frames, then flywheels on the frame period. While locked it qualifies payload bits and frame boundaries for the downstream decoder, and it drops lock after repeated head misses.

## Interface
- HEAD, 6'b100101, frame head pattern; the MSB is received first
- HEAD_LEN, 6, head length in bits
- FRAME_LEN, 32, bits per frame including the head; must be > HEAD_LEN
- LOCK_CNT, 3, consecutive good heads needed to lock, counting the first detection; ≥ 2
- LOSS_CNT, 3, consecutive missed heads in SYNC that force HUNT; ≥ 1

Ports:
- clk_sys  in  1  system clock; all logic on its rising edge
- reset  in  1  synchronous, active-high; overrides all other inputs
- bit_en  in  1  one-cycle strobe per received bit; the only event that advances state
- bit_in  in  1  received bit, valid when bit_en=1
- locked  out  1  high while the state is SYNC
- frame_start  out  1  one-cycle pulse coincident with the first payload bit of a locked frame
- payload_en  out  1  one-cycle pulse per payload bit while locked
- payload_bit  out  1  registered payload bit, valid when payload_en=1
- head_miss  out  1  one-cycle pulse when an expected head mismatches in CHECK or SYNC
- bit_pos  out  $clog2(FRAME_LEN)  current position counter, for debug
- state  out  2  HUNT=0, CHECK=1, SYNC=2

## Operation
- `shreg`[HEAD_LEN-1:0] shifts left on each bit_en, inserting bit_in at the LSB.
- `cand` = {shreg[HEAD_LEN-2:0], bit_in}, i.e. the window including the current bit.
- `pos` (bit_pos) counts bits after a head end:
  - set to 0 on the bit_en that completes a detected or expected head;
  - otherwise increments on each bit_en;
  - the expected head completes on the bit_en where pos == FRAME_LEN-1. That bit_en is the "check slot"; pos wraps to 0 there regardless of match.
- HUNT:
  - every bit_en with cand == HEAD → CHECK, pos ← 0, hits ← 1;
  - otherwise stay in HUNT, and pos is don't-care.
- CHECK, at the check slot:
  - match → hits+1; if hits+1 == LOCK_CNT → SYNC, misses ← 0;
  - mismatch → HUNT, head_miss pulse;
  - the search resumes on the next bit_en, and the mismatching bit is not re-examined as a new head.
- SYNC, at the check slot:
  - match → misses ← 0;
  - mismatch → misses+1 and head_miss pulse; if misses+1 == LOSS_CNT → HUNT.
- Payload: in SYNC, a bit_en with pos (before update) in 0..FRAME_LEN-HEAD_LEN-1 is a payload bit.
  - payload_en pulses and payload_bit ← bit_in;
  - frame_start also pulses when pos == 0.
  - FRAME_LEN-HEAD_LEN = 26 payload bits per frame at the defaults.
- Transition rules:
  - the payload decision uses the state before the bit_en update, so no payload is flagged on the check slot that enters SYNC;
  - the frame following that check slot is fully flagged;
  - the check slot that drops to HUNT flags nothing, since check slots are head bits.
- Counter widths: hits and misses are wide enough for LOCK_CNT and LOSS_CNT and never wrap.

## Timing
- Reset values on the cycle after reset is sampled high:
  - state=HUNT, locked=0, frame_start=0, payload_en=0, payload_bit=0, head_miss=0, bit_pos=0;
  - shreg=0, hits=0, misses=0.
- All outputs are registered: a response appears on the cycle after the bit_en that causes it.
- locked follows the state register, so it changes on the same edge as state.
- Pulses (frame_start, payload_en, head_miss) last exactly one cycle, even if bit_en is high on consecutive cycles.
- bit_en may be high every cycle; back-to-back bits must be handled.
- With bit_en=0, nothing changes and the pulse outputs are 0.
- Reset mid-frame, including while locked, clears everything with no residual pulse. Hunting restarts from an empty shreg.

## Test plan
Defaults throughout; bit_en every 4th cycle unless stated otherwise.
- Reset with random inputs → all outputs 0, state=0 on the cycle after reset; they stay 0 with bit_en=0 for 50 cycles.
- Clean stream of frames (100101 + 26 random bits, repeated) starting at an arbitrary offset:
  - state goes HUNT→CHECK at head 1 and SYNC at head 3;
  - locked=1 one cycle after the last bit of head 3;
  - each later frame gives 26 payload_en pulses matching the sent bits, and one frame_start with the first of them.
- Head pattern embedded in the payload of frame 1, then a mismatch 32 bits later → CHECK→HUNT with one head_miss pulse; lock is still reached on the true heads.
- Locked, then 2 corrupted heads followed by a good head → locked stays 1, two head_miss pulses, misses cleared. Three consecutive corrupted heads → locked=0 one cycle after the third check slot, and payload_en stops.
- bit_en held high every cycle on the clean stream → same lock point in bit count; payload_bit matches for every bit.
- Reset asserted for one cycle while locked mid-payload → all outputs 0 on the next cycle; relock after 3 more heads.
